// File: rtl/vga_pkg.sv
// Shared geometry, clear colour and FSM encoding for the pixel sink framebuffer.
// Addressing assumes a 160-wide buffer so y*160 becomes two shifts and an add.
package vga_pkg;
  localparam int X_PIXELS = 160;
  localparam int Y_PIXELS = 120;
  localparam int FB_DEPTH = X_PIXELS * Y_PIXELS;
  localparam int ADDR_W   = 15;
  localparam logic [2:0] CLEAR_COLOUR = 3'b000;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } plot_t;

  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [7:0] x, input logic [6:0] y);
    logic [ADDR_W-1:0] y_w;
    y_w = {8'd0, y};
    return (y_w << 7) + (y_w << 5) + {7'd0, x};
  endfunction
endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer storage: one synchronous write, one synchronous read.
// Both ports update on the same edge, so a colliding read returns the old word.
module fb_ram #(
  parameter int DEPTH  = vga_pkg::FB_DEPTH,
  parameter int ADDR_W = vga_pkg::ADDR_W,
  parameter int DATA_W = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge Clock) begin
    if (!Reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/pixel_sink.sv
// Framebuffer sink: sweeps the buffer to CLEAR_COLOUR, then accepts pixel plots
// and services one-cycle-latency reads in either state.
//
// state    | meaning
// ST_CLEAR | sweeping CLEAR_COLOUR over every address, plots dropped, busy=1
// ST_RUN   | accepting plots and clear requests
module pixel_sink #(
  parameter int X_PIXELS = vga_pkg::X_PIXELS,
  parameter int Y_PIXELS = vga_pkg::Y_PIXELS,
  parameter logic [2:0] CLEAR_COLOUR = vga_pkg::CLEAR_COLOUR
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  iX,
  input  logic [6:0]  iY,
  input  logic [2:0]  iColour,
  input  logic        iPlot,
  input  logic        iClear,
  input  logic        rdReq,
  input  logic [7:0]  rdX,
  input  logic [6:0]  rdY,
  output logic        rdValid,
  output logic [2:0]  rdColour,
  output logic        busy,
  output logic        frameDone,
  output logic        errFlag,
  output logic [14:0] pixelCount
);
  import vga_pkg::*;

  logic [0:0]        state;
  logic [ADDR_W-1:0] sweep_addr;
  plot_t             plot;
  logic              plot_in_range;
  logic              plot_last;
  logic              plot_accept;
  logic              rd_in_range;
  logic              rd_oob;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [2:0]        wdata;
  logic [2:0]        ram_q;

  assign plot          = '{x: iX, y: iY, colour: iColour};
  assign plot_in_range = (int'(plot.x) < X_PIXELS) && (int'(plot.y) < Y_PIXELS);
  assign plot_last     = (int'(plot.x) == X_PIXELS - 1) && (int'(plot.y) == Y_PIXELS - 1);
  assign plot_accept   = (state == ST_RUN) && iPlot && !iClear && plot_in_range;
  assign rd_in_range   = (int'(rdX) < X_PIXELS) && (int'(rdY) < Y_PIXELS);

  assign busy = (state == ST_CLEAR);

  // Reset low holds the sweep at address 0, so nothing is written until release.
  assign we    = Reset && (busy || plot_accept);
  assign waddr = busy ? sweep_addr : pixel_addr(plot.x, plot.y);
  assign wdata = busy ? CLEAR_COLOUR : plot.colour;

  fb_ram u_fb_ram (
    .Clock (Clock),
    .Reset (Reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (rdReq && rd_in_range),
    .raddr (pixel_addr(rdX, rdY)),
    .rdata (ram_q)
  );

  // Out-of-range reads never touch the RAM; the flag substitutes the clear colour.
  assign rdColour = rd_oob ? CLEAR_COLOUR : ram_q;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state      <= ST_CLEAR;
      sweep_addr <= '0;
      pixelCount <= '0;
      errFlag    <= 1'b0;
      frameDone  <= 1'b0;
      rdValid    <= 1'b0;
      rd_oob     <= 1'b0;
    end else begin
      frameDone <= plot_accept && plot_last;
      rdValid   <= rdReq;
      if (rdReq) rd_oob <= !rd_in_range;

      case (state)
        ST_CLEAR: begin
          if (sweep_addr == LAST_ADDR) begin
            state      <= ST_RUN;
            sweep_addr <= '0;
          end else begin
            sweep_addr <= sweep_addr + 1'b1;
          end
        end
        default: begin
          if (iClear) begin
            state      <= ST_CLEAR;
            sweep_addr <= '0;
            pixelCount <= '0;
            errFlag    <= 1'b0;
          end else if (iPlot) begin
            if (!plot_in_range) begin
              errFlag <= 1'b1;
            end else if (pixelCount != 15'h7FFF) begin
              pixelCount <= pixelCount + 15'd1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_sink.sv
// Directed bench for pixel_sink: clear timing, plot/read paths, error and frame flags.
module tb_pixel_sink;
  logic        Clock = 1'b0;
  logic        Reset;
  logic [7:0]  iX;
  logic [6:0]  iY;
  logic [2:0]  iColour;
  logic        iPlot;
  logic        iClear;
  logic        rdReq;
  logic [7:0]  rdX;
  logic [6:0]  rdY;
  logic        rdValid;
  logic [2:0]  rdColour;
  logic        busy;
  logic        frameDone;
  logic        errFlag;
  logic [14:0] pixelCount;

  int errors = 0;
  int checks = 0;

  pixel_sink dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iX         (iX),
    .iY         (iY),
    .iColour    (iColour),
    .iPlot      (iPlot),
    .iClear     (iClear),
    .rdReq      (rdReq),
    .rdX        (rdX),
    .rdY        (rdY),
    .rdValid    (rdValid),
    .rdColour   (rdColour),
    .busy       (busy),
    .frameDone  (frameDone),
    .errFlag    (errFlag),
    .pixelCount (pixelCount)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Counts busy cycles from the current one; start carries cycles already spent in CLEAR.
  task automatic wait_clear(input string tag, input int start);
    int n;
    n = start;
    while (busy === 1'b1 && n < 25000) begin
      n++;
      tick();
    end
    check(tag, 16'(n), 16'd19200);
  endtask

  task automatic read_px(input logic [7:0] x, input logic [6:0] y);
    rdReq = 1'b1;
    rdX   = x;
    rdY   = y;
    tick();
    rdReq = 1'b0;
  endtask

  task automatic plot_px(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    iPlot   = 1'b1;
    iX      = x;
    iY      = y;
    iColour = c;
    tick();
    iPlot = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; iX = '0; iY = '0; iColour = '0; iPlot = 1'b0; iClear = 1'b0;
    rdReq = 1'b1; rdX = '0; rdY = '0;
    repeat (3) tick();
    check("rst_busy", 16'(busy), 16'd1);
    check("rst_rdValid", 16'(rdValid), 16'd0);
    check("rst_rdColour", 16'(rdColour), 16'd0);
    check("rst_frameDone", 16'(frameDone), 16'd0);
    check("rst_errFlag", 16'(errFlag), 16'd0);
    check("rst_pixelCount", 16'(pixelCount), 16'd0);

    Reset = 1'b1;
    rdReq = 1'b0;
    wait_clear("busy_after_reset", 0);

    rdReq = 1'b1; rdX = 8'd0; rdY = 7'd0;
    tick();
    check("rd00_valid", 16'(rdValid), 16'd1);
    check("rd00_colour", 16'(rdColour), 16'd0);
    rdX = 8'd159; rdY = 7'd119;
    tick();
    rdReq = 1'b0;
    check("rd_last_valid", 16'(rdValid), 16'd1);
    check("rd_last_colour", 16'(rdColour), 16'd0);

    plot_px(8'd5, 7'd3, 3'b101);
    check("idle_rdValid", 16'(rdValid), 16'd0);
    check("count_after_plot", 16'(pixelCount), 16'd1);
    read_px(8'd5, 7'd3);
    check("rd53_valid", 16'(rdValid), 16'd1);
    check("rd53_colour", 16'(rdColour), 16'd5);
    check("no_frameDone", 16'(frameDone), 16'd0);
    tick();
    check("hold_rdValid", 16'(rdValid), 16'd0);
    check("hold_rdColour", 16'(rdColour), 16'd5);

    plot_px(8'd159, 7'd119, 3'b111);
    check("frameDone_pulse", 16'(frameDone), 16'd1);
    check("count_after_last", 16'(pixelCount), 16'd2);
    tick();
    check("frameDone_end", 16'(frameDone), 16'd0);

    plot_px(8'd160, 7'd0, 3'b011);
    check("oob_errFlag", 16'(errFlag), 16'd1);
    check("oob_count", 16'(pixelCount), 16'd2);

    rdReq = 1'b1; rdX = 8'd200; rdY = 7'd5;
    tick();
    check("oob_rd_valid", 16'(rdValid), 16'd1);
    check("oob_rd_colour", 16'(rdColour), 16'd0);
    rdX = 8'd159; rdY = 7'd119;
    tick();
    rdReq = 1'b0;
    check("b2b_rd_colour", 16'(rdColour), 16'd7);

    plot_px(8'd10, 7'd10, 3'b010);
    iPlot = 1'b1; iX = 8'd10; iY = 7'd10; iColour = 3'b100;
    rdReq = 1'b1; rdX = 8'd10; rdY = 7'd10;
    tick();
    iPlot = 1'b0;
    check("rbw_old", 16'(rdColour), 16'd2);
    check("rbw_count", 16'(pixelCount), 16'd4);
    tick();
    rdReq = 1'b0;
    check("rbw_new", 16'(rdColour), 16'd4);

    iClear = 1'b1; iPlot = 1'b1; iX = 8'd1; iY = 7'd1; iColour = 3'b110;
    tick();
    check("clr_busy", 16'(busy), 16'd1);
    check("clr_count", 16'(pixelCount), 16'd0);
    check("clr_errFlag", 16'(errFlag), 16'd0);
    iX = 8'd200; iY = 7'd0;
    rdReq = 1'b1; rdX = 8'd159; rdY = 7'd119;
    tick();
    rdReq = 1'b0;
    check("rd_in_clear_valid", 16'(rdValid), 16'd1);
    check("rd_in_clear_colour", 16'(rdColour), 16'd7);
    repeat (98) tick();
    check("clear_plot_no_err", 16'(errFlag), 16'd0);
    check("clear_plot_no_count", 16'(pixelCount), 16'd0);
    iClear = 1'b0; iPlot = 1'b0;
    wait_clear("busy_after_iClear", 99);

    read_px(8'd1, 7'd1);
    check("clr_rd11", 16'(rdColour), 16'd0);
    read_px(8'd5, 7'd3);
    check("clr_rd53", 16'(rdColour), 16'd0);
    read_px(8'd10, 7'd10);
    check("clr_rd1010", 16'(rdColour), 16'd0);
    read_px(8'd159, 7'd119);
    check("clr_rd_last", 16'(rdColour), 16'd0);
    check("post_clr_count", 16'(pixelCount), 16'd0);
    check("post_clr_err", 16'(errFlag), 16'd0);

    plot_px(8'd100, 7'd100, 3'b110);
    plot_px(8'd200, 7'd0, 3'b001);
    check("pre_rst_count", 16'(pixelCount), 16'd1);
    check("pre_rst_err", 16'(errFlag), 16'd1);
    read_px(8'd100, 7'd100);
    check("pre_rst_rd", 16'(rdColour), 16'd6);

    Reset = 1'b0; rdReq = 1'b1;
    tick();
    check("midrun_rst_busy", 16'(busy), 16'd1);
    check("midrun_rst_count", 16'(pixelCount), 16'd0);
    check("midrun_rst_err", 16'(errFlag), 16'd0);
    check("midrun_rst_rdValid", 16'(rdValid), 16'd0);
    check("midrun_rst_rdColour", 16'(rdColour), 16'd0);
    Reset = 1'b1; rdReq = 1'b0;
    repeat (5000) tick();
    check("sweep5000_busy", 16'(busy), 16'd1);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    wait_clear("busy_after_midclear_reset", 0);
    read_px(8'd100, 7'd100);
    check("post_rst_rd", 16'(rdColour), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pixel_sink.md
PIXEL_SINK -- requirements
Module: pixel_sink

Interface
REQ-001 Parameter X_PIXELS, default 160: horizontal resolution.
REQ-002 Parameter Y_PIXELS, default 120: vertical resolution.
REQ-003 Parameter CLEAR_COLOUR, default 3'b000: colour written during clear.
REQ-004 Clock  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-005 Reset  input  1  reset, synchronous, active-low.
REQ-006 iX  input  8  plot column.
REQ-007 iY  input  7  plot row.
REQ-008 iColour  input  3  plot colour {R,G,B}.
REQ-009 iPlot  input  1  write strobe; one pixel per high cycle.
REQ-010 iClear  input  1  request a full-buffer clear.
REQ-011 rdReq  input  1  read request for (rdX,rdY).
REQ-012 rdX  input  8  read column.
REQ-013 rdY  input  7  read row.
REQ-014 rdValid  output  1  rdColour valid this cycle.
REQ-015 rdColour  output  3  read data.
REQ-016 busy  output  1  clear in progress; plots ignored.
REQ-017 frameDone  output  1  one-cycle pulse on an accepted write to the last pixel.
REQ-018 errFlag  output  1  sticky: an out-of-range plot occurred.
REQ-019 pixelCount  output  15  accepted writes since last clear.

Function
REQ-020 The block SHALL hold an X_PIXELS*Y_PIXELS x 3-bit buffer (19200 entries by default), addressed as y*X_PIXELS+x, computed in 15 bits as (y<<7)+(y<<5)+x with no multiplier.
REQ-021 The FSM SHALL have two states: CLEAR and RUN.
REQ-022 In CLEAR, the block SHALL write CLEAR_COLOUR to one address per cycle, ascending from 0 to 19199, then move to RUN in the next cycle; busy=1 throughout CLEAR.
REQ-023 busy SHALL stay high for exactly 19200 cycles after the Reset release or clear start, then go low.
REQ-024 In RUN, iClear=1 SHALL enter CLEAR on the next edge, zero pixelCount and clear errFlag.
REQ-025 In CLEAR, iClear SHALL be ignored; the sweep SHALL NOT restart.
REQ-026 In RUN, iPlot=1 with iX<X_PIXELS and iY<Y_PIXELS SHALL write iColour on that edge and increment pixelCount.
REQ-027 pixelCount SHALL saturate at 32767.
REQ-028 An out-of-range plot in RUN SHALL be dropped and SHALL set errFlag.
REQ-029 Plots during CLEAR SHALL be dropped silently, with no errFlag set and no count.
REQ-030 If iPlot and iClear are high in the same RUN cycle, the plot SHALL be dropped and the clear SHALL win.
REQ-031 frameDone SHALL pulse high the cycle after an accepted write to (X_PIXELS-1, Y_PIXELS-1), with no other effect.
REQ-032 Read latency SHALL be 1: rdReq at edge N gives rdValid=1 and rdColour during cycle N+1; back-to-back requests SHALL be accepted every cycle.
REQ-033 An out-of-range read SHALL return rdValid=1 with rdColour=CLEAR_COLOUR.
REQ-034 Reads SHALL be serviced in both states.
REQ-035 A read and a write to the same address on the same edge SHALL return the old data (read-before-write).
REQ-036 When rdReq=0, rdValid SHALL be 0 in the next cycle and rdColour SHALL hold its value.

Reset
REQ-037 While Reset=0 at an edge: state SHALL be CLEAR with the sweep address at 0, busy=1, rdValid=0, rdColour=0, frameDone=0, errFlag=0, pixelCount=0.
REQ-038 Reset asserted mid-clear or mid-run SHALL restart the sweep from address 0; buffer contents are replaced by that sweep.

Structure
REQ-039 Package vga_pkg SHALL hold X_PIXELS, Y_PIXELS, FB_DEPTH (19200), CLEAR_COLOUR and the FSM state encoding.
REQ-040 Storage SHALL be a sub-module fb_ram: simple dual-port, 1 sync write port, 1 sync read port, 15-bit address, 3-bit data, read-before-write.

Verification
REQ-041 Release reset, then count cycles: busy=1 for exactly 19200 cycles; a read of (0,0) and of (159,119) afterwards returns 3'b000.
REQ-042 Plot (5,3,3'b101), then read (5,3): rdValid and rdColour=3'b101 one cycle after rdReq; pixelCount=1.
REQ-043 Plot (159,119,3'b111): frameDone is high for exactly one cycle; plot (160,0): errFlag=1 and pixelCount is unchanged.
REQ-044 Write (10,10,3'b010), then on the same edge write (10,10,3'b100) and read it: read returns 3'b010; the next read returns 3'b100.
REQ-045 Raise iClear together with a plot at (1,1): the plot is dropped; after 19200 cycles all reads return 0, pixelCount=0 and errFlag=0.
REQ-046 Assert Reset at sweep address 5000: busy stays high for 19200 cycles after release.
